alu_seq: RTL and testbench

- Registered, parametrised accumulator ALU for the AC/DR datapath. Generalises the combinational 16-bit ALU.
- Adds width and IP-width parameters, a start/done handshake, a zero flag, subtract and shift operations, and a multi-cycle shift-add multiply.
- Sits between the accumulator/data registers and the AC write-back mux. The controller issues one operation per start pulse and waits for done.

---
 rtl/alu_seq.sv | 135 +++++++++++++
 tb/tb_alu_seq.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Registered accumulator ALU for the AC/DR datapath: single-cycle ops plus a
// multi-cycle shift-add multiply, with a start/done handshake.
module alu_seq #(
   parameter int WIDTH = 16,
   parameter int IPW   = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [3:0]       ctrl,
   input  logic             cin,
   input  logic [WIDTH-1:0] ac,
   input  logic [WIDTH-1:0] dr,
   input  logic [IPW-1:0]   ip,
   output logic [WIDTH-1:0] alu_out,
   output logic             cout,
   output logic             zero,
   output logic             busy,
   output logic             done
);

   localparam int CNTW = $clog2(WIDTH + 1);

   localparam logic S_IDLE = 1'b0;
   localparam logic S_MUL  = 1'b1;

   localparam logic [3:0] OP_ADD   = 4'd0;
   localparam logic [3:0] OP_AND   = 4'd1;
   localparam logic [3:0] OP_NOT   = 4'd2;
   localparam logic [3:0] OP_INC   = 4'd3;
   localparam logic [3:0] OP_DEC   = 4'd4;
   localparam logic [3:0] OP_LDIP  = 4'd5;
   localparam logic [3:0] OP_SUB   = 4'd6;
   localparam logic [3:0] OP_LDCIN = 4'd7;
   localparam logic [3:0] OP_SHL   = 4'd8;
   localparam logic [3:0] OP_SHR   = 4'd9;
   localparam logic [3:0] OP_MUL   = 4'd10;

   logic                 r_state;
   logic [WIDTH-1:0]     r_alu_out;
   logic                 r_cout;
   logic                 r_zero;
   logic                 r_busy;
   logic                 r_done;
   logic [2*WIDTH-1:0]   r_mcand;
   logic [WIDTH-1:0]     r_mplier;
   logic [2*WIDTH-1:0]   r_acc;
   logic [CNTW-1:0]      r_cnt;

   logic [WIDTH-1:0]     w_res;
   logic                 w_cout;
   logic [2*WIDTH-1:0]   w_acc_next;

   // NOTE: every always_comb output gets a default first, so no path infers a latch.
   always_comb begin
      w_res  = r_alu_out;
      w_cout = r_cout;
      unique case (ctrl)
         OP_ADD:   {w_cout, w_res} = {1'b0, ac} + {1'b0, dr};
         OP_AND:   begin w_res = ac & dr; w_cout = 1'b0; end
         OP_NOT:   begin w_res = ~ac;     w_cout = 1'b0; end
         OP_INC:   {w_cout, w_res} = {1'b0, ac} + (WIDTH + 1)'(1);
         OP_DEC:   {w_cout, w_res} = {1'b0, ac} - (WIDTH + 1)'(1);
         OP_LDIP:  begin w_res = WIDTH'(ip);  w_cout = 1'b0; end
         OP_SUB:   {w_cout, w_res} = {1'b0, ac} - {1'b0, dr};
         OP_LDCIN: begin w_res = WIDTH'(cin); w_cout = 1'b0; end
         OP_SHL:   begin w_res = {ac[WIDTH-2:0], cin}; w_cout = ac[WIDTH-1]; end
         OP_SHR:   begin w_res = {cin, ac[WIDTH-1:1]}; w_cout = ac[0]; end
         default:  ; // reserved opcodes (and MUL, handled by the FSM) hold
      endcase
   end

   assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);

   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples values from before the edge regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_alu_out <= '0;
         r_cout    <= 1'b0;
         r_zero    <= 1'b1;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_mcand   <= '0;
         r_mplier  <= '0;
         r_acc     <= '0;
         r_cnt     <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  if (ctrl == OP_MUL) begin
                     r_state  <= S_MUL;
                     r_busy   <= 1'b1;
                     r_mcand  <= {{WIDTH{1'b0}}, ac};
                     r_mplier <= dr;
                     r_acc    <= '0;
                     r_cnt    <= CNTW'(WIDTH);
                  end else begin
                     r_alu_out <= w_res;
                     r_cout    <= w_cout;
                     r_zero    <= (w_res == '0);
                     r_done    <= 1'b1;
                  end
               end
            end
            S_MUL: begin
               r_acc    <= w_acc_next;
               r_mcand  <= r_mcand << 1;
               r_mplier <= r_mplier >> 1;
               r_cnt    <= r_cnt - CNTW'(1);
               // Final iteration: the product is complete in w_acc_next.
               if (r_cnt == CNTW'(1)) begin
                  r_alu_out <= w_acc_next[WIDTH-1:0];
                  r_cout    <= |w_acc_next[2*WIDTH-1:WIDTH];
                  r_zero    <= (w_acc_next[WIDTH-1:0] == '0);
                  r_done    <= 1'b1;
                  r_busy    <= 1'b0;
                  r_state   <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign alu_out = r_alu_out;
   assign cout    = r_cout;
   assign zero    = r_zero;
   assign busy    = r_busy;
   assign done    = r_done;

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq: a 16-bit instance and an 8-bit/IPW=4 instance.
module tb_alu_seq;

   logic clk;
   logic rst;

   logic        start;
   logic [3:0]  ctrl;
   logic        cin;
   logic [15:0] ac, dr;
   logic [7:0]  ip;
   logic [15:0] alu_out;
   logic        cout, zero, busy, done;

   logic        start8;
   logic [3:0]  ctrl8;
   logic        cin8;
   logic [7:0]  ac8, dr8;
   logic [3:0]  ip8;
   logic [7:0]  alu_out8;
   logic        cout8, zero8, busy8, done8;

   int n_checks = 0;
   int n_errors = 0;

   alu_seq #(.WIDTH(16), .IPW(8)) dut (
      .clk(clk), .rst(rst), .start(start), .ctrl(ctrl), .cin(cin),
      .ac(ac), .dr(dr), .ip(ip),
      .alu_out(alu_out), .cout(cout), .zero(zero), .busy(busy), .done(done)
   );

   alu_seq #(.WIDTH(8), .IPW(4)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .ctrl(ctrl8), .cin(cin8),
      .ac(ac8), .dr(dr8), .ip(ip8),
      .alu_out(alu_out8), .cout(cout8), .zero(zero8), .busy(busy8), .done(done8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Applies one start pulse to the 16-bit instance; returns #1 after the accepting edge.
   task automatic op16(input logic [3:0] c, input logic [15:0] a, input logic [15:0] d,
                       input logic [7:0] p, input logic ci);
      @(negedge clk);
      ctrl = c; ac = a; dr = d; ip = p; cin = ci; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   typedef struct {
      logic [3:0]  c;
      logic [15:0] a;
      logic [15:0] d;
      logic [15:0] exp_out;
      logic        exp_cout;
   } vec_t;

   vec_t b2b[5];

   int done_k;
   int n_done;

   initial begin
      b2b[0] = '{4'd0, 16'h1234, 16'h1111, 16'h2345, 1'b0};
      b2b[1] = '{4'd6, 16'h0001, 16'h0001, 16'h0000, 1'b0};
      b2b[2] = '{4'd2, 16'h00FF, 16'h0000, 16'hFF00, 1'b0};
      b2b[3] = '{4'd1, 16'hF0F0, 16'h3C3C, 16'h3030, 1'b0};
      b2b[4] = '{4'd3, 16'h7FFF, 16'h0000, 16'h8000, 1'b0};

      start = 0; ctrl = 0; cin = 0; ac = 0; dr = 0; ip = 0;
      start8 = 0; ctrl8 = 0; cin8 = 0; ac8 = 0; dr8 = 0; ip8 = 0;
      rst = 1'b1;
      #12;
      chk("rst_alu_out", 32'(alu_out), 32'h0);
      chk("rst_cout", 32'(cout), 32'h0);
      chk("rst_zero", 32'(zero), 32'h1);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_done", 32'(done), 32'h0);
      @(negedge clk);
      rst = 1'b0;

      op16(4'd0, 16'hFFFF, 16'h0001, 8'h00, 1'b0);
      chk("add_out", 32'(alu_out), 32'h0);
      chk("add_cout", 32'(cout), 32'h1);
      chk("add_zero", 32'(zero), 32'h1);
      chk("add_done", 32'(done), 32'h1);
      chk("add_busy", 32'(busy), 32'h0);
      @(posedge clk); #1;
      chk("add_done_drop", 32'(done), 32'h0);
      chk("add_hold_out", 32'(alu_out), 32'h0);

      op16(4'd4, 16'h0000, 16'h0000, 8'h00, 1'b0);
      chk("dec_out", 32'(alu_out), 32'hFFFF);
      chk("dec_cout", 32'(cout), 32'h1);
      chk("dec_zero", 32'(zero), 32'h0);

      op16(4'd6, 16'd5, 16'd7, 8'h00, 1'b0);
      chk("sub_out", 32'(alu_out), 32'hFFFE);
      chk("sub_cout", 32'(cout), 32'h1);

      op16(4'd5, 16'h1234, 16'h0000, 8'hA5, 1'b0);
      chk("ldip_out", 32'(alu_out), 32'h00A5);
      chk("ldip_cout", 32'(cout), 32'h0);

      op16(4'd8, 16'h8001, 16'h0000, 8'h00, 1'b1);
      chk("shl_out", 32'(alu_out), 32'h0003);
      chk("shl_cout", 32'(cout), 32'h1);

      op16(4'd9, 16'h0001, 16'h0000, 8'h00, 1'b1);
      chk("shr_out", 32'(alu_out), 32'h8000);
      chk("shr_cout", 32'(cout), 32'h1);

      op16(4'd3, 16'hFFFF, 16'h0000, 8'h00, 1'b0);
      chk("inc_wrap_out", 32'(alu_out), 32'h0000);
      chk("inc_wrap_cout", 32'(cout), 32'h1);

      op16(4'd7, 16'hABCD, 16'h0000, 8'h00, 1'b1);
      chk("ldcin_out", 32'(alu_out), 32'h0001);
      chk("ldcin_cout", 32'(cout), 32'h0);

      op16(4'd12, 16'hFFFF, 16'hFFFF, 8'hFF, 1'b1);
      chk("rsvd_out", 32'(alu_out), 32'h0001);
      chk("rsvd_cout", 32'(cout), 32'h0);
      chk("rsvd_zero", 32'(zero), 32'h0);
      chk("rsvd_done", 32'(done), 32'h1);

      // Back-to-back single-cycle ops with start held high.
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         ctrl = b2b[i].c; ac = b2b[i].a; dr = b2b[i].d; start = 1'b1;
         @(posedge clk); #1;
         chk($sformatf("b2b%0d_out", i), 32'(alu_out), 32'(b2b[i].exp_out));
         chk($sformatf("b2b%0d_cout", i), 32'(cout), 32'(b2b[i].exp_cout));
         chk($sformatf("b2b%0d_zero", i), 32'(zero), 32'(b2b[i].exp_out == 16'h0));
         chk($sformatf("b2b%0d_done", i), 32'(done), 32'h1);
      end
      start = 1'b0;

      // MUL 300*300 with a stray start mid-multiply.
      op16(4'd10, 16'd300, 16'd300, 8'h00, 1'b0);
      chk("mul_busy_start", 32'(busy), 32'h1);
      chk("mul_done_start", 32'(done), 32'h0);
      done_k = -1;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         start = (k == 3);
         ctrl = (k == 3) ? 4'd0 : 4'd10;
         ac = 16'd1; dr = 16'd1;
         @(posedge clk); #1;
         if (k == 15) chk("mul_busy_late", 32'(busy), 32'h1);
         if (done) begin
            done_k = k;
            break;
         end
      end
      start = 1'b0;
      chk("mul_latency", 32'(done_k), 32'd16);
      chk("mul_out", 32'(alu_out), 32'h5F90);
      chk("mul_cout", 32'(cout), 32'h1);
      chk("mul_zero", 32'(zero), 32'h0);
      chk("mul_busy_end", 32'(busy), 32'h0);
      @(posedge clk); #1;
      chk("mul_done_once", 32'(done), 32'h0);
      chk("mul_hold_out", 32'(alu_out), 32'h5F90);

      // Asynchronous reset during the 5th multiply iteration.
      op16(4'd10, 16'd300, 16'd300, 8'h00, 1'b0);
      repeat (4) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      chk("arst_out", 32'(alu_out), 32'h0);
      chk("arst_cout", 32'(cout), 32'h0);
      chk("arst_zero", 32'(zero), 32'h1);
      chk("arst_busy", 32'(busy), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      n_done = 0;
      for (int k = 0; k < 24; k++) begin
         @(posedge clk); #1;
         if (done) n_done++;
      end
      chk("arst_no_done", 32'(n_done), 32'd0);
      op16(4'd0, 16'd2, 16'd3, 8'h00, 1'b0);
      chk("post_rst_add_out", 32'(alu_out), 32'd5);
      chk("post_rst_add_done", 32'(done), 32'h1);
      chk("post_rst_add_cout", 32'(cout), 32'h0);

      // 8-bit instance: LDIP then MUL 16*16 overflowing to zero.
      @(negedge clk);
      ctrl8 = 4'd5; ip8 = 4'hF; start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0;
      chk("w8_ldip_out", 32'(alu_out8), 32'h0F);
      chk("w8_ldip_zero", 32'(zero8), 32'h0);
      @(negedge clk);
      ctrl8 = 4'd10; ac8 = 8'd16; dr8 = 8'd16; start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0;
      done_k = -1;
      for (int k = 1; k <= 30; k++) begin
         @(posedge clk); #1;
         if (done8) begin
            done_k = k;
            break;
         end
      end
      chk("w8_mul_latency", 32'(done_k), 32'd8);
      chk("w8_mul_out", 32'(alu_out8), 32'h00);
      chk("w8_mul_cout", 32'(cout8), 32'h1);
      chk("w8_mul_zero", 32'(zero8), 32'h1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
